traffic_intersection_ctrl: RTL and testbench

- Parametrised two-road intersection controller: main road A, side road B, one pedestrian crossing over road A.
- Adds the following:
  - Per-phase programmable durations.
  - All-red clearance intervals.
  - Demand-driven extension of the A green (side-road car sensor, pedestrian request).
  - Latched pedestrian requests with a walk signal.
  - Night-mode yellow flashing.
- Drives lamp pins directly from the top-level pad wrapper.

---
 rtl/traffic_intersection_ctrl.sv | 166 ++++++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller: main road A, side road B, and a
// pedestrian crossing over road A. Road A rests on green until a car waits
// on B or a pedestrian asks to cross. All-red clearance separates the
// greens, and night mode flashes both yellows.
module traffic_intersection_ctrl #(
    parameter int CNT_W     = 8,
    parameter int T_GREEN_A = 20,
    parameter int T_GREEN_B = 10,
    parameter int T_YELLOW  = 3,
    parameter int T_ALLRED  = 2,
    parameter int T_WALK    = 8,
    parameter int FLASH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       night_mode,
    input  logic       sensor_b,
    input  logic       ped_req,
    output logic [2:0] lights_a,
    output logic [2:0] lights_b,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        A_GREEN  = 3'd1,
        A_YELLOW = 3'd2,
        ALLRED_1 = 3'd3,
        B_GREEN  = 3'd4,
        B_YELLOW = 3'd5,
        ALLRED_2 = 3'd6,
        FLASH    = 3'd7
    } state_t;

    // Each phase ends on the cycle where the counter reaches its duration minus one.
    localparam logic [CNT_W-1:0] L_GA_LAST  = CNT_W'(T_GREEN_A - 1);
    localparam logic [CNT_W-1:0] L_GB_LAST  = CNT_W'(T_GREEN_B - 1);
    localparam logic [CNT_W-1:0] L_Y_LAST   = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] L_AR_LAST  = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] L_FD_LAST  = CNT_W'(FLASH_DIV - 1);
    localparam logic [CNT_W-1:0] L_WALK_LEN = CNT_W'(T_WALK);

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_flashCnt;
    logic             r_flashOff;
    logic             r_pedPending;
    logic             r_walkGrant;
    logic             w_enterB;
    logic             w_enterFlash;
    logic             w_demand;

    assign w_enterB     = (w_next == B_GREEN) && (r_state != B_GREEN);
    assign w_enterFlash = (w_next == FLASH) && (r_state != FLASH);
    assign w_demand     = sensor_b | r_pedPending | ped_req;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection; a low enable beats every other transition.
    always_comb begin
        w_next = r_state;
        if (!en) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:     w_next = ALLRED_2;
                A_GREEN:  if (r_cnt == L_GA_LAST && w_demand) w_next = A_YELLOW;
                A_YELLOW: if (r_cnt == L_Y_LAST) w_next = ALLRED_1;
                ALLRED_1: if (r_cnt == L_AR_LAST) w_next = night_mode ? FLASH : B_GREEN;
                B_GREEN:  if (r_cnt == L_GB_LAST) w_next = B_YELLOW;
                B_YELLOW: if (r_cnt == L_Y_LAST) w_next = ALLRED_2;
                ALLRED_2: if (r_cnt == L_AR_LAST) w_next = night_mode ? FLASH : A_GREEN;
                FLASH:    if (!night_mode) w_next = ALLRED_2;
                default:  w_next = IDLE;
            endcase
        end
    end

    // Phase counter: cleared on entry, parked at the last A-green count so late demand exits at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state == A_GREEN && r_cnt == L_GA_LAST) begin
            r_cnt <= r_cnt;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Flash divider: yellows start lit on FLASH entry, then swap every FLASH_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flashCnt <= '0;
            r_flashOff <= 1'b0;
        end else if (w_enterFlash) begin
            r_flashCnt <= '0;
            r_flashOff <= 1'b0;
        end else if (r_state == FLASH) begin
            if (r_flashCnt == L_FD_LAST) begin
                r_flashCnt <= '0;
                r_flashOff <= ~r_flashOff;
            end else begin
                r_flashCnt <= r_flashCnt + 1'b1;
            end
        end
    end

    // Pedestrian latch; a request seen on the B-green entry edge is folded into that grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pedPending <= 1'b0;
            r_walkGrant  <= 1'b0;
        end else if (w_enterB) begin
            r_pedPending <= 1'b0;
            r_walkGrant  <= r_pedPending | ped_req;
        end else if (ped_req) begin
            r_pedPending <= 1'b1;
        end
    end

    // Output decode from registered state only, so no input reaches a pin combinationally.
    always_comb begin
        lights_a = LAMP_OFF;
        lights_b = LAMP_OFF;
        walk     = 1'b0;
        ped_ack  = 1'b0;
        phase    = r_state;
        case (r_state)
            A_GREEN:  begin lights_a = LAMP_G; lights_b = LAMP_R; end
            A_YELLOW: begin lights_a = LAMP_Y; lights_b = LAMP_R; end
            ALLRED_1: begin lights_a = LAMP_R; lights_b = LAMP_R; end
            B_GREEN: begin
                lights_a = LAMP_R;
                lights_b = LAMP_G;
                walk     = r_walkGrant && (r_cnt < L_WALK_LEN);
                ped_ack  = r_walkGrant && (r_cnt == '0);
            end
            B_YELLOW: begin lights_a = LAMP_R; lights_b = LAMP_Y; end
            ALLRED_2: begin lights_a = LAMP_R; lights_b = LAMP_R; end
            FLASH: begin
                lights_a = r_flashOff ? LAMP_OFF : LAMP_Y;
                lights_b = r_flashOff ? LAMP_OFF : LAMP_Y;
            end
            default: begin lights_a = LAMP_OFF; lights_b = LAMP_OFF; end
        endcase
    end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench for traffic_intersection_ctrl with default parameters.
// Every expected phase, lamp and pedestrian value is written out by hand.
module tb_traffic_intersection_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       night_mode;
    logic       sensor_b;
    logic       ped_req;
    logic [2:0] lights_a;
    logic [2:0] lights_b;
    logic       walk;
    logic       ped_ack;
    logic [2:0] phase;

    int total = 0;
    int bad   = 0;

    traffic_intersection_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .night_mode (night_mode),
        .sensor_b   (sensor_b),
        .ped_req    (ped_req),
        .lights_a   (lights_a),
        .lights_b   (lights_b),
        .walk       (walk),
        .ped_ack    (ped_ack),
        .phase      (phase)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive all functional inputs at once.
    task automatic applyStimulus(input logic iEn, input logic iNight, input logic iSensor, input logic iPed);
        en         = iEn;
        night_mode = iNight;
        sensor_b   = iSensor;
        ped_req    = iPed;
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check a non-B-green phase for n cycles, leaving the bench on the next phase's first cycle.
    task automatic holdPhase(input string tag, input logic [2:0] p, input int n,
                             input logic [2:0] a, input logic [2:0] b);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s.phase[%0d]", tag, i), phase, p);
            checkOutput($sformatf("%s.a[%0d]", tag, i), lights_a, a);
            checkOutput($sformatf("%s.b[%0d]", tag, i), lights_b, b);
            checkOutput($sformatf("%s.walk[%0d]", tag, i), {2'b00, walk}, 3'b000);
            checkOutput($sformatf("%s.ack[%0d]", tag, i), {2'b00, ped_ack}, 3'b000);
            stepCycle();
        end
    endtask

    // Check B-green cycles first..first+n-1; walk covers cycles 0..7, ack only cycle 0.
    task automatic walkPhase(input string tag, input logic grant, input int first, input int n);
        logic expWalk;
        logic expAck;
        for (int i = first; i < first + n; i++) begin
            expWalk = grant && (i < 8);
            expAck  = grant && (i == 0);
            checkOutput($sformatf("%s.phase[%0d]", tag, i), phase, 3'd4);
            checkOutput($sformatf("%s.a[%0d]", tag, i), lights_a, 3'b100);
            checkOutput($sformatf("%s.b[%0d]", tag, i), lights_b, 3'b001);
            checkOutput($sformatf("%s.walk[%0d]", tag, i), {2'b00, walk}, {2'b00, expWalk});
            checkOutput($sformatf("%s.ack[%0d]", tag, i), {2'b00, ped_ack}, {2'b00, expAck});
            stepCycle();
        end
    endtask

    // Check n FLASH cycles: yellows lit for 4, dark for 4, repeating.
    task automatic flashPhase(input string tag, input int n);
        logic [2:0] expY;
        for (int i = 0; i < n; i++) begin
            expY = (((i / 4) % 2) == 0) ? 3'b010 : 3'b000;
            checkOutput($sformatf("%s.phase[%0d]", tag, i), phase, 3'd7);
            checkOutput($sformatf("%s.a[%0d]", tag, i), lights_a, expY);
            checkOutput($sformatf("%s.b[%0d]", tag, i), lights_b, expY);
            checkOutput($sformatf("%s.walk[%0d]", tag, i), {2'b00, walk}, 3'b000);
            stepCycle();
        end
    endtask

    // Run from A_GREEN cycle 0 with a waiting B car up to B_GREEN cycle 0.
    task automatic carCycleToB(input string tag);
        sensor_b = 1'b1;
        holdPhase({tag, ".ag"}, 3'd1, 20, 3'b001, 3'b100);
        sensor_b = 1'b0;
        holdPhase({tag, ".ay"}, 3'd2, 3, 3'b010, 3'b100);
        holdPhase({tag, ".ar1"}, 3'd3, 2, 3'b100, 3'b100);
    endtask

    // Directed scenario sequence.
    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        stepCycle();
        checkOutput("rst.phase", phase, 3'd0);
        checkOutput("rst.a", lights_a, 3'b000);
        checkOutput("rst.b", lights_b, 3'b000);
        checkOutput("rst.walk", {2'b00, walk}, 3'b000);
        checkOutput("rst.ack", {2'b00, ped_ack}, 3'b000);

        // Start-up through ALLRED_2, then A green rests with no demand.
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        stepCycle();
        holdPhase("start.ar2", 3'd6, 2, 3'b100, 3'b100);
        holdPhase("start.ag", 3'd1, 30, 3'b001, 3'b100);

        // Single-cycle pedestrian press during the extension exits on the next edge.
        ped_req = 1'b1;
        stepCycle();
        ped_req = 1'b0;
        holdPhase("ped.ay", 3'd2, 3, 3'b010, 3'b100);
        holdPhase("ped.ar1", 3'd3, 2, 3'b100, 3'b100);
        walkPhase("ped.bg", 1'b1, 0, 10);
        holdPhase("ped.by", 3'd5, 3, 3'b100, 3'b010);
        holdPhase("ped.ar2", 3'd6, 2, 3'b100, 3'b100);

        // Car arrives at A_GREEN cycle 5; A green still lasts exactly 20 cycles.
        holdPhase("sens.ag0", 3'd1, 5, 3'b001, 3'b100);
        sensor_b = 1'b1;
        holdPhase("sens.ag5", 3'd1, 15, 3'b001, 3'b100);
        holdPhase("sens.ay", 3'd2, 3, 3'b010, 3'b100);
        holdPhase("sens.ar1", 3'd3, 2, 3'b100, 3'b100);
        sensor_b = 1'b0;
        walkPhase("sens.bg", 1'b0, 0, 10);
        holdPhase("sens.by", 3'd5, 3, 3'b100, 3'b010);
        holdPhase("sens.ar2", 3'd6, 2, 3'b100, 3'b100);

        // Request on the last ALLRED_1 cycle is granted straight away and not carried over.
        sensor_b = 1'b1;
        holdPhase("sim.ag", 3'd1, 20, 3'b001, 3'b100);
        sensor_b = 1'b0;
        holdPhase("sim.ay", 3'd2, 3, 3'b010, 3'b100);
        holdPhase("sim.ar1a", 3'd3, 1, 3'b100, 3'b100);
        ped_req = 1'b1;
        holdPhase("sim.ar1b", 3'd3, 1, 3'b100, 3'b100);
        ped_req = 1'b0;
        walkPhase("sim.bg", 1'b1, 0, 10);
        holdPhase("sim.by", 3'd5, 3, 3'b100, 3'b010);
        holdPhase("sim.ar2", 3'd6, 2, 3'b100, 3'b100);
        carCycleToB("sim2");
        walkPhase("sim2.bg", 1'b0, 0, 10);

        // Night mode raised mid B green: B finishes, then FLASH after ALLRED_2.
        holdPhase("ngt.by0", 3'd5, 3, 3'b100, 3'b010);
        holdPhase("ngt.ar2a", 3'd6, 2, 3'b100, 3'b100);
        carCycleToB("ngt");
        walkPhase("ngt.bg0", 1'b0, 0, 5);
        night_mode = 1'b1;
        walkPhase("ngt.bg5", 1'b0, 5, 5);
        holdPhase("ngt.by", 3'd5, 3, 3'b100, 3'b010);
        holdPhase("ngt.ar2", 3'd6, 2, 3'b100, 3'b100);
        flashPhase("ngt.fl", 12);
        night_mode = 1'b0;
        stepCycle();
        holdPhase("day.ar2", 3'd6, 2, 3'b100, 3'b100);
        checkOutput("day.ag", phase, 3'd1);

        // Disable during B_YELLOW drops to IDLE, re-enable restarts via ALLRED_2.
        carCycleToB("dis");
        walkPhase("dis.bg", 1'b0, 0, 10);
        holdPhase("dis.by", 3'd5, 1, 3'b100, 3'b010);
        en = 1'b0;
        stepCycle();
        holdPhase("dis.idle", 3'd0, 2, 3'b000, 3'b000);
        en = 1'b1;
        stepCycle();
        holdPhase("dis.ar2", 3'd6, 2, 3'b100, 3'b100);

        // Request held pending through A green, then reset mid B green wipes a fresh request.
        ped_req = 1'b1;
        holdPhase("rb.ag0", 3'd1, 1, 3'b001, 3'b100);
        ped_req = 1'b0;
        holdPhase("rb.ag1", 3'd1, 19, 3'b001, 3'b100);
        holdPhase("rb.ay", 3'd2, 3, 3'b010, 3'b100);
        holdPhase("rb.ar1", 3'd3, 2, 3'b100, 3'b100);
        walkPhase("rb.bg0", 1'b1, 0, 3);
        ped_req = 1'b1;
        walkPhase("rb.bg3", 1'b1, 3, 1);
        ped_req = 1'b0;
        rst_n = 1'b0;
        #2;
        checkOutput("rb.rst.phase", phase, 3'd0);
        checkOutput("rb.rst.a", lights_a, 3'b000);
        checkOutput("rb.rst.b", lights_b, 3'b000);
        checkOutput("rb.rst.walk", {2'b00, walk}, 3'b000);
        rst_n = 1'b1;
        stepCycle();
        holdPhase("rb.ar2", 3'd6, 2, 3'b100, 3'b100);
        carCycleToB("rb2");
        walkPhase("rb2.bg", 1'b0, 0, 10);
        holdPhase("rb2.by", 3'd5, 3, 3'b100, 3'b010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
